// File: rtl/jpeg_blk_sched_if.sv
// jpeg_blk_sched_if: scheduler <-> requesters/datapath bundle; optional JPEG_BLK_SCHED_STATS_EN adds blk_cnt/stats_clr
interface jpeg_blk_sched_if #(parameter int NREQ = 3);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            dp_valid;
    logic            dp_ready;
    logic [5:0]      coef_idx;
    logic            blk_first;
    logic            blk_last;
    logic            blk_done;
    logic            busy;
`ifdef JPEG_BLK_SCHED_STATS_EN
    logic [NREQ*16-1:0] blk_cnt;
    logic               stats_clr;
    modport master (input req, dp_ready, stats_clr,
                    output gnt, dp_valid, coef_idx, blk_first, blk_last, blk_done, busy, blk_cnt);
    modport slave  (output req, dp_ready, stats_clr,
                    input gnt, dp_valid, coef_idx, blk_first, blk_last, blk_done, busy, blk_cnt);
`else
    modport master (input req, dp_ready,
                    output gnt, dp_valid, coef_idx, blk_first, blk_last, blk_done, busy);
    modport slave  (output req, dp_ready,
                    input gnt, dp_valid, coef_idx, blk_first, blk_last, blk_done, busy);
`endif
endinterface

// File: rtl/jpeg_blk_sched.sv
// jpeg_blk_sched: round-robin block scheduler for a shared 8x8 quantize/encode datapath; JPEG_BLK_SCHED_STATS_EN adds per-requester block counters
module jpeg_blk_sched #(
    parameter int NREQ     = 3,
    parameter int PIPE_LAT = 4,
    parameter int COEF_N   = 64
) (
    input logic            clk,
    input logic            rst,
    jpeg_blk_sched_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, RUN, DRAIN} state_t;
    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] sel;
    logic          found;
    logic [3:0]    cnt;
    logic          xfer;
    logic          last;
    assign xfer     = bus.dp_valid && bus.dp_ready;
    assign last     = bus.coef_idx == 6'(COEF_N - 1);
    assign bus.busy = state != IDLE;
    // first requesting index at or after the pointer, wrapping
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++)
            if (!found && bus.req[PW'((int'(ptr) + k) % NREQ)]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + k) % NREQ);
            end
    end
    // block sequencer: arbitrate, setup, stream COEF_N beats, drain pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.gnt       <= '0;
            bus.dp_valid  <= 1'b0;
            bus.coef_idx  <= '0;
            bus.blk_first <= 1'b0;
            bus.blk_last  <= 1'b0;
            bus.blk_done  <= 1'b0;
            ptr           <= '0;
            gidx          <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    bus.gnt <= NREQ'(1) << sel;
                    gidx    <= sel;
                    state   <= GRANT;
                end
                GRANT: begin
                    bus.dp_valid  <= 1'b1;
                    bus.blk_first <= 1'b1;
                    bus.blk_last  <= (COEF_N == 1);
                    state         <= RUN;
                end
                RUN: if (xfer) begin
                    bus.coef_idx  <= last ? 6'd0 : bus.coef_idx + 6'd1;
                    bus.blk_first <= 1'b0;
                    bus.blk_last  <= !last && bus.coef_idx == 6'(COEF_N - 2);
                    if (last) begin
                        bus.dp_valid <= 1'b0;
                        bus.blk_done <= (PIPE_LAT == 1);
                        cnt          <= 4'(PIPE_LAT - 1);
                        state        <= DRAIN;
                    end
                end
                DRAIN: if (cnt == 4'd0) begin
                    bus.blk_done <= 1'b0;
                    bus.gnt      <= '0;
                    ptr          <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    state        <= IDLE;
                end else begin
                    cnt          <= cnt - 4'd1;
                    bus.blk_done <= (cnt == 4'd1);
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef JPEG_BLK_SCHED_STATS_EN
    // saturating per-requester completed-block counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.blk_cnt <= '0;
        else
            for (int i = 0; i < NREQ; i++)
                if (bus.stats_clr) bus.blk_cnt[16*i +: 16] <= '0;
                else if (bus.blk_done && gidx == PW'(i) && bus.blk_cnt[16*i +: 16] != 16'hFFFF)
                    bus.blk_cnt[16*i +: 16] <= bus.blk_cnt[16*i +: 16] + 16'd1;
    end
`endif
endmodule
